sr_bank_driver: RTL and testbench

//  Command-side driver for a bank of WIDTH SR flip-flops. Accepts a target word over a

---
 rtl/sr_drv_pkg.sv | 26 ++
 rtl/sr_pulse_timer.sv | 34 +++
 rtl/sr_bank_driver.sv | 176 +++++++++++++++++
 tb/tb_sr_bank_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and defaults for the SR bank driver: FSM state encoding,
// default parameter values and the timer width helper.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4
  } drv_state_e;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_PULSE_CYCLES  = 1;
  localparam int unsigned DEF_SETTLE_CYCLES = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to hold the largest of the pulse and settle reload values.
  function automatic int unsigned timer_width(input int unsigned pulse, input int unsigned settle);
    return $clog2(max_u(pulse, settle) + 1);
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with a zero flag; times the pulse and settle phases.
module sr_pulse_timer #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_bank_driver.sv
// Command-side driver for a bank of SR flip-flops: turns a target word into
// non-overlapping per-bit S/R pulses, then verifies the readback.
module sr_bank_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] shadow_q,
  output logic             done,
  output logic             mismatch
);

  localparam int unsigned CW = timer_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] S_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  drv_state_e       state_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] set_m_q;
  logic [WIDTH-1:0] rst_m_q;
  logic [WIDTH-1:0] shadow_r_q;
  logic [WIDTH-1:0] s_out_q;
  logic [WIDTH-1:0] r_out_q;
  logic             tgt_ready_q;
  logic             done_q;
  logic             mismatch_q;
  logic             init_busy_q;

  logic             hs;
  logic             no_change;
  logic [WIDTH-1:0] new_set;
  logic [WIDTH-1:0] new_rst;
  logic             tmr_load;
  logic [CW-1:0]    tmr_val;
  logic             tmr_zero;

  assign hs        = (state_q == ST_IDLE) && tgt_valid && tgt_ready_q;
  assign no_change = (tgt_data == shadow_r_q);
  assign new_set   = tgt_data & ~shadow_r_q;
  assign new_rst   = ~tgt_data & shadow_r_q;

  // Timer reload on entry to every timed phase (INIT pulse, DRIVE, SETTLE).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = P_LOAD;
    case (state_q)
      ST_INIT: begin
        if (!init_busy_q) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = S_LOAD;
        end
      end
      ST_IDLE: begin
        if (hs && !no_change) begin
          tmr_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = S_LOAD;
        end
      end
      default: ;
    endcase
  end

  sr_pulse_timer #(
    .CW(CW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  // init_busy_q marks the power-up clear: set on the first INIT cycle, and the
  // CHECK that ends it updates mismatch without emitting done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      target_q    <= '0;
      set_m_q     <= '0;
      rst_m_q     <= '0;
      shadow_r_q  <= '0;
      s_out_q     <= '0;
      r_out_q     <= '0;
      tgt_ready_q <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      init_busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (!init_busy_q) begin
            init_busy_q <= 1'b1;
            target_q    <= '0;
            s_out_q     <= '0;
            r_out_q     <= '1;
          end else if (tmr_zero) begin
            r_out_q <= '0;
            state_q <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
          end
        end
        ST_IDLE: begin
          if (hs) begin
            tgt_ready_q <= 1'b0;
            target_q    <= tgt_data;
            set_m_q     <= new_set;
            rst_m_q     <= new_rst;
            if (no_change) begin
              state_q <= ST_CHECK;
            end else begin
              s_out_q <= new_set;
              r_out_q <= new_rst;
              state_q <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (tmr_zero) begin
            s_out_q <= '0;
            r_out_q <= '0;
            state_q <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
          end else begin
            s_out_q <= set_m_q;
            r_out_q <= rst_m_q;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          shadow_r_q  <= target_q;
          mismatch_q  <= (q_in != target_q);
          tgt_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
          if (init_busy_q) begin
            init_busy_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          s_out_q <= '0;
          r_out_q <= '0;
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign tgt_ready = tgt_ready_q;
  assign s_out     = s_out_q;
  assign r_out     = r_out_q;
  assign shadow_q  = shadow_r_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver with an SR bank model and an expected-result queue.
module tb_sr_bank_driver;

  localparam int unsigned W = 8;
  localparam int unsigned P = 1;
  localparam int unsigned S = 1;
  localparam int unsigned LAT_CHG = P + S + 1;
  localparam int unsigned LIMIT   = 40;

  typedef struct {
    logic [W-1:0] shadow;
    logic         mism;
    int unsigned  lat;
    logic [W-1:0] set_m;
    logic [W-1:0] rst_m;
    int unsigned  act;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_data = '0;
  logic         tgt_ready;
  logic [W-1:0] s_out;
  logic [W-1:0] r_out;
  logic [W-1:0] q_in;
  logic [W-1:0] shadow_q;
  logic         done;
  logic         mismatch;

  logic [W-1:0] bank = '0;
  logic [W-1:0] stuck = '0;
  logic [W-1:0] tb_shadow = '0;
  int unsigned  done_cnt = 0;
  logic         overlap_seen = 1'b0;
  exp_t         sb_q[$];
  int unsigned  total = 0;
  int unsigned  passed = 0;

  sr_bank_driver #(
    .WIDTH(W),
    .PULSE_CYCLES(P),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_valid(tgt_valid),
    .tgt_data (tgt_data),
    .tgt_ready(tgt_ready),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_in     (q_in),
    .shadow_q (shadow_q),
    .done     (done),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  // SR bank on the same clock; stuck bits read back as 0.
  always_ff @(posedge clk) bank <= (bank | s_out) & ~r_out;
  assign q_in = bank & ~stuck;

  always_ff @(posedge clk) begin
    done_cnt <= done_cnt + (done ? 1 : 0);
    if ((s_out & r_out) != '0) overlap_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [W-1:0] data);
    exp_t e;
    exp_t got;
    logic [W-1:0] s_seen;
    logic [W-1:0] r_seen;
    int unsigned act;
    int unsigned lat;
    int unsigned n;
    n = 0;
    while (tgt_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_cmd", 32'(tgt_ready), 32'(1'b1));
    e.shadow = data;
    e.mism   = ((data & stuck) != '0);
    e.set_m  = data & ~tb_shadow;
    e.rst_m  = ~data & tb_shadow;
    e.lat    = (data == tb_shadow) ? 1 : LAT_CHG;
    e.act    = (data == tb_shadow) ? 0 : P;
    sb_q.push_back(e);
    tgt_valid = 1'b1;
    tgt_data  = data;
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_data  = ~data;
    s_seen = '0;
    r_seen = '0;
    act = 0;
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      s_seen |= s_out;
      r_seen |= r_out;
      if ((s_out | r_out) != '0) act++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(done), 32'(1'b1));
    got = sb_q.pop_front();
    check("latency", lat, got.lat);
    check("shadow_q", 32'(shadow_q), 32'(got.shadow));
    check("mismatch", 32'(mismatch), 32'(got.mism));
    check("s_pattern", 32'(s_seen), 32'(got.set_m));
    check("r_pattern", 32'(r_seen), 32'(got.rst_m));
    check("pulse_cycles", act, got.act);
    check("ready_with_done", 32'(tgt_ready), 32'(1'b1));
    tb_shadow = data;
  endtask

  initial begin
    int unsigned n;
    int unsigned dc;

    // Reset state
    @(negedge clk);
    check("rst_s_out", 32'(s_out), 32'h0);
    check("rst_r_out", 32'(r_out), 32'h0);
    check("rst_ready", 32'(tgt_ready), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_shadow", 32'(shadow_q), 32'h0);
    check("rst_mismatch", 32'(mismatch), 32'h0);

    // INIT clear sequence
    bank = 8'h5A;
    rst = 1'b0;
    @(negedge clk);
    check("init_r_on", 32'(r_out), 32'hFF);
    check("init_s_off", 32'(s_out), 32'h0);
    check("init_ready_lo", 32'(tgt_ready), 32'h0);
    @(negedge clk);
    check("init_r_off", 32'(r_out), 32'h0);
    @(negedge clk);
    check("init_ready_c3", 32'(tgt_ready), 32'h0);
    @(negedge clk);
    check("init_ready_c4", 32'(tgt_ready), 32'h1);
    check("init_shadow", 32'(shadow_q), 32'h0);
    check("init_mismatch", 32'(mismatch), 32'h0);
    check("init_no_done", done_cnt, 0);

    // Commands, back-to-back
    send(8'hA5);
    send(8'h3C);
    send(8'h3C);

    // Stuck readback bit
    stuck = 8'h01;
    send(8'h01);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'h0);
    @(negedge clk);
    check("mismatch_holds", 32'(mismatch), 32'h1);
    send(8'h80);
    stuck = '0;

    // Reset in the middle of DRIVE
    n = 0;
    while (tgt_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    tgt_valid = 1'b1;
    tgt_data  = 8'h0F;
    @(negedge clk);
    tgt_valid = 1'b0;
    check("mid_drive_s", 32'(s_out), 32'h0F);
    check("mid_drive_r", 32'(r_out), 32'h80);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_s", 32'(s_out), 32'h0);
    check("abort_r", 32'(r_out), 32'h0);
    check("abort_ready", 32'(tgt_ready), 32'h0);
    check("abort_shadow", 32'(shadow_q), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("replay_r_on", 32'(r_out), 32'hFF);
    n = 0;
    while (tgt_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("replay_ready_cycles", n, 3);
    check("abort_no_done", done_cnt, dc);
    tb_shadow = '0;
    send(8'hFF);
    send(8'h00);

    @(negedge clk);
    @(negedge clk);
    check("no_overlap", 32'(overlap_seen), 32'h0);
    check("done_total", done_cnt, 7);
    check("queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
